// File: rtl/valu_issue_ctrl.sv
// Issue-side sequencer for the 16-lane vector ALU: latches one instruction, starts the ALU,
// waits on valu_done under a watchdog, and hands the captured results to writeback.
module valu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [31:0]  issue_control,
    input  logic [511:0] issue_src1_data,
    input  logic [511:0] issue_src2_data,
    input  logic [511:0] issue_src3_data,
    input  logic [15:0]  issue_vcc_value,
    input  logic [15:0]  issue_exec_value,
    input  logic [9:0]   issue_vgpr_addr,
    input  logic [8:0]   issue_sgpr_addr,
    input  logic         issue_wr_vgpr,
    input  logic         issue_wr_sgpr,
    input  logic         issue_wr_vcc,

    output logic [511:0] alu_source1_data,
    output logic [511:0] alu_source2_data,
    output logic [511:0] alu_source3_data,
    output logic [15:0]  alu_source_vcc_value,
    output logic [15:0]  alu_source_exec_value,
    output logic [31:0]  alu_control,
    output logic         alu_start,
    input  logic [511:0] alu_vgpr_dest_data,
    input  logic [15:0]  alu_sgpr_dest_data,
    input  logic [15:0]  alu_dest_vcc_value,
    input  logic [15:0]  alu_dest_exec_value,
    input  logic         valu_done,

    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [511:0] wb_vgpr_data,
    output logic [15:0]  wb_sgpr_data,
    output logic [15:0]  wb_vcc_value,
    output logic [15:0]  wb_exec_value,
    output logic [9:0]   wb_vgpr_addr,
    output logic [8:0]   wb_sgpr_addr,
    output logic         wb_vgpr_en,
    output logic         wb_sgpr_en,
    output logic         wb_vcc_en,

    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]  control;
        logic [511:0] src1;
        logic [511:0] src2;
        logic [511:0] src3;
        logic [15:0]  vcc;
        logic [15:0]  exec;
        logic [9:0]   vgpr_addr;
        logic [8:0]   sgpr_addr;
        logic         wr_vgpr;
        logic         wr_sgpr;
        logic         wr_vcc;
    } inst_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nxt;
    inst_t      inst;
    logic [7:0] wd_cnt;
    logic       accept;
    logic       capture;

    assign accept  = (state == IDLE) && issue_valid;
    assign capture = (state == WAIT) && valu_done;

    // NOTE: every register below uses non-blocking assignment so all state updates see
    // pre-edge values, regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The instruction register is cleared on reset too, so a reset mid-operation leaves
    // nothing from the aborted instruction visible once the ALU outputs are ungated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= '0;
        end else if (accept) begin
            inst <= '{control:   issue_control,
                      src1:      issue_src1_data,
                      src2:      issue_src2_data,
                      src3:      issue_src3_data,
                      vcc:       issue_vcc_value,
                      exec:      issue_exec_value,
                      vgpr_addr: issue_vgpr_addr,
                      sgpr_addr: issue_sgpr_addr,
                      wr_vgpr:   issue_wr_vgpr,
                      wr_sgpr:   issue_wr_sgpr,
                      wr_vcc:    issue_wr_vcc};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Addresses and enables come from the instruction, never from the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vgpr_data  <= '0;
            wb_sgpr_data  <= '0;
            wb_vcc_value  <= '0;
            wb_exec_value <= '0;
            wb_vgpr_addr  <= '0;
            wb_sgpr_addr  <= '0;
            wb_vgpr_en    <= 1'b0;
            wb_sgpr_en    <= 1'b0;
            wb_vcc_en     <= 1'b0;
        end else if (capture) begin
            wb_vgpr_data  <= alu_vgpr_dest_data;
            wb_sgpr_data  <= alu_sgpr_dest_data;
            wb_vcc_value  <= alu_dest_vcc_value;
            wb_exec_value <= alu_dest_exec_value;
            wb_vgpr_addr  <= inst.vgpr_addr;
            wb_sgpr_addr  <= inst.sgpr_addr;
            wb_vgpr_en    <= inst.wr_vgpr;
            wb_sgpr_en    <= inst.wr_sgpr;
            wb_vcc_en     <= inst.wr_vcc;
        end
    end

    // NOTE: every output of this block is given a default first, so no path through the
    // case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid && (issue_control != 32'd0)) begin
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                // valu_done wins over the watchdog when both land in the same cycle.
                if (valu_done) begin
                    state_nxt = WB;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt   = IDLE;
                    err_timeout = 1'b1;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue_ready           = (state == IDLE);
        busy                  = (state != IDLE);
        alu_start             = (state == START);
        wb_valid              = (state == WB);
        alu_source1_data      = '0;
        alu_source2_data      = '0;
        alu_source3_data      = '0;
        alu_source_vcc_value  = '0;
        alu_source_exec_value = '0;
        alu_control           = '0;
        if (state != IDLE) begin
            alu_source1_data      = inst.src1;
            alu_source2_data      = inst.src2;
            alu_source3_data      = inst.src3;
            alu_source_vcc_value  = inst.vcc;
            alu_source_exec_value = inst.exec;
        end
        // Control is withdrawn outside START/WAIT so the ALU cannot raise valu_done unowned.
        if ((state == START) || (state == WAIT)) begin
            alu_control = inst.control;
        end
    end

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Self-checking bench for valu_issue_ctrl: directed and randomized instructions against a
// transaction-level model of the expected handshake timing and writeback contents.
module tb_valu_issue_ctrl;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue_valid;
    logic         issue_ready;
    logic [31:0]  issue_control;
    logic [511:0] issue_src1_data, issue_src2_data, issue_src3_data;
    logic [15:0]  issue_vcc_value, issue_exec_value;
    logic [9:0]   issue_vgpr_addr;
    logic [8:0]   issue_sgpr_addr;
    logic         issue_wr_vgpr, issue_wr_sgpr, issue_wr_vcc;
    logic [511:0] alu_source1_data, alu_source2_data, alu_source3_data;
    logic [15:0]  alu_source_vcc_value, alu_source_exec_value;
    logic [31:0]  alu_control;
    logic         alu_start;
    logic [511:0] alu_vgpr_dest_data;
    logic [15:0]  alu_sgpr_dest_data, alu_dest_vcc_value, alu_dest_exec_value;
    logic         valu_done;
    logic         wb_valid;
    logic         wb_ready;
    logic [511:0] wb_vgpr_data;
    logic [15:0]  wb_sgpr_data, wb_vcc_value, wb_exec_value;
    logic [9:0]   wb_vgpr_addr;
    logic [8:0]   wb_sgpr_addr;
    logic         wb_vgpr_en, wb_sgpr_en, wb_vcc_en;
    logic         busy;
    logic         err_timeout;

    int checks = 0;
    int errors = 0;

    valu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_control(issue_control),
        .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
        .issue_src3_data(issue_src3_data), .issue_vcc_value(issue_vcc_value),
        .issue_exec_value(issue_exec_value), .issue_vgpr_addr(issue_vgpr_addr),
        .issue_sgpr_addr(issue_sgpr_addr), .issue_wr_vgpr(issue_wr_vgpr),
        .issue_wr_sgpr(issue_wr_sgpr), .issue_wr_vcc(issue_wr_vcc),
        .alu_source1_data(alu_source1_data), .alu_source2_data(alu_source2_data),
        .alu_source3_data(alu_source3_data), .alu_source_vcc_value(alu_source_vcc_value),
        .alu_source_exec_value(alu_source_exec_value), .alu_control(alu_control),
        .alu_start(alu_start), .alu_vgpr_dest_data(alu_vgpr_dest_data),
        .alu_sgpr_dest_data(alu_sgpr_dest_data), .alu_dest_vcc_value(alu_dest_vcc_value),
        .alu_dest_exec_value(alu_dest_exec_value), .valu_done(valu_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vgpr_data(wb_vgpr_data),
        .wb_sgpr_data(wb_sgpr_data), .wb_vcc_value(wb_vcc_value),
        .wb_exec_value(wb_exec_value), .wb_vgpr_addr(wb_vgpr_addr),
        .wb_sgpr_addr(wb_sgpr_addr), .wb_vgpr_en(wb_vgpr_en), .wb_sgpr_en(wb_sgpr_en),
        .wb_vcc_en(wb_vcc_en), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] observed,
                         input logic [511:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Stand-in ALU behaviour: lane result = (a + b) ^ c, scalar outputs derived from masks.
    function automatic logic [511:0] model_vgpr(input logic [511:0] a, input logic [511:0] b,
                                                input logic [511:0] c);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = (a[i*32 +: 32] + b[i*32 +: 32]) ^ c[i*32 +: 32];
        return r;
    endfunction

    task automatic drive_alu_garbage;
        alu_vgpr_dest_data  = rand512();
        alu_sgpr_dest_data  = 16'($urandom);
        alu_dest_vcc_value  = 16'($urandom);
        alu_dest_exec_value = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_issue_ready"}, issue_ready, 1);
        check({ph, "_alu_start"}, alu_start, 0);
        check({ph, "_alu_control"}, alu_control, 0);
        check({ph, "_alu_src1"}, alu_source1_data, 0);
        check({ph, "_alu_src3"}, alu_source3_data, 0);
        check({ph, "_alu_exec"}, alu_source_exec_value, 0);
        check({ph, "_wb_valid"}, wb_valid, 0);
        check({ph, "_wb_vgpr_data"}, wb_vgpr_data, 0);
        check({ph, "_wb_vgpr_en"}, {wb_vgpr_en, wb_sgpr_en, wb_vcc_en}, 0);
        check({ph, "_wb_addr"}, {wb_vgpr_addr, wb_sgpr_addr}, 0);
        check({ph, "_busy"}, busy, 0);
        check({ph, "_err_timeout"}, err_timeout, 0);
    endtask

    // One instruction end to end. done_wait = WAIT cycle index in which the ALU reports done
    // (>= TO means never); bp = cycles of wb_ready low in WB; stale = valu_done high in START.
    task automatic run_op(input string nm, input logic [31:0] ctrl, input logic [15:0] exec,
                          input int done_wait, input int bp, input bit stale, input bit fives);
        logic [511:0] s1, s2, s3, exp_vgpr;
        logic [15:0]  vcc;
        logic [9:0]   va;
        logic [8:0]   sa;
        logic [2:0]   en;
        bit           finished;
        int           k;
        s1  = rand512();
        s2  = rand512();
        s3  = rand512();
        if (fives) for (int i = 0; i < 16; i++) s1[i*32 +: 32] = 32'h5;
        vcc = 16'($urandom);
        va  = 10'($urandom);
        sa  = 9'($urandom);
        en  = 3'($urandom);
        if (fives) en[2] = 1'b1;
        exp_vgpr = model_vgpr(s1, s2, s3);

        issue_valid = 1'b1;   issue_control = ctrl;
        issue_src1_data = s1; issue_src2_data = s2; issue_src3_data = s3;
        issue_vcc_value = vcc; issue_exec_value = exec;
        issue_vgpr_addr = va; issue_sgpr_addr = sa;
        {issue_wr_vgpr, issue_wr_sgpr, issue_wr_vcc} = en;
        #1;
        check({nm, "_ready_before"}, issue_ready, 1);
        tick;
        // Scramble the issue bus: the controller must work from its latched copy.
        issue_valid = 1'b0;
        issue_control = $urandom;
        issue_src1_data = rand512();
        issue_exec_value = 16'($urandom);
        {issue_wr_vgpr, issue_wr_sgpr, issue_wr_vcc} = ~en;

        check({nm, "_start"}, alu_start, 1);
        check({nm, "_start_ready"}, issue_ready, 0);
        check({nm, "_start_ctrl"}, alu_control, ctrl);
        check({nm, "_start_src1"}, alu_source1_data, s1);
        check({nm, "_start_exec"}, alu_source_exec_value, exec);
        valu_done = stale;
        drive_alu_garbage();
        tick;

        finished = 0;
        k = 0;
        while (!finished) begin
            check({nm, "_wait_start"}, alu_start, 0);
            check({nm, "_wait_ctrl"}, alu_control, ctrl);
            check({nm, "_wait_wbv"}, wb_valid, 0);
            check({nm, "_wait_busy"}, busy, 1);
            if (k == done_wait) begin
                valu_done = 1'b1;
                alu_vgpr_dest_data  = exp_vgpr;
                alu_sgpr_dest_data  = vcc ^ exec;
                alu_dest_vcc_value  = vcc & exec;
                alu_dest_exec_value = exec;
            end else begin
                valu_done = 1'b0;
                drive_alu_garbage();
            end
            #1;
            check({nm, "_err_timeout"}, err_timeout, (k != done_wait) && (k == TO - 1));
            tick;
            if (k == done_wait || k == TO - 1) finished = 1;
            k++;
        end

        valu_done = 1'b0;
        drive_alu_garbage();
        if (done_wait < TO) begin
            check({nm, "_wb_valid"}, wb_valid, 1);
            check({nm, "_wb_vgpr"}, wb_vgpr_data, exp_vgpr);
            check({nm, "_wb_sgpr"}, wb_sgpr_data, vcc ^ exec);
            check({nm, "_wb_vcc"}, wb_vcc_value, vcc & exec);
            check({nm, "_wb_exec"}, wb_exec_value, exec);
            check({nm, "_wb_addr"}, {wb_vgpr_addr, wb_sgpr_addr}, {va, sa});
            check({nm, "_wb_en"}, {wb_vgpr_en, wb_sgpr_en, wb_vcc_en}, en);
            check({nm, "_wb_ctrl"}, alu_control, 0);
            check({nm, "_wb_no_err"}, err_timeout, 0);
            wb_ready = 1'b0;
            for (int c = 0; c < bp; c++) begin
                tick;
                drive_alu_garbage();
                check({nm, "_bp_valid"}, wb_valid, 1);
                check({nm, "_bp_vgpr"}, wb_vgpr_data, exp_vgpr);
                check({nm, "_bp_meta"}, {wb_exec_value, wb_vgpr_addr, wb_vgpr_en}, {exec, va, en[2]});
                check({nm, "_bp_ready"}, issue_ready, 0);
                check({nm, "_bp_ctrl"}, alu_control, 0);
            end
            wb_ready = 1'b1;
            tick;
            wb_ready = 1'b0;
        end
        check({nm, "_idle_ready"}, issue_ready, 1);
        check({nm, "_idle_wbv"}, wb_valid, 0);
        check({nm, "_idle_busy"}, busy, 0);
        check({nm, "_idle_err"}, err_timeout, 0);
        check({nm, "_idle_ctrl"}, alu_control, 0);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_control = '0;
        issue_src1_data = '0; issue_src2_data = '0; issue_src3_data = '0;
        issue_vcc_value = '0; issue_exec_value = '0;
        issue_vgpr_addr = '0; issue_sgpr_addr = '0;
        issue_wr_vgpr = 1'b0; issue_wr_sgpr = 1'b0; issue_wr_vcc = 1'b0;
        alu_vgpr_dest_data = '0; alu_sgpr_dest_data = '0;
        alu_dest_vcc_value = '0; alu_dest_exec_value = '0;
        valu_done = 1'b0; wb_ready = 1'b0;
        tick;
        tick;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick;

        run_op("single", 32'h1, 16'hFFFF, 1, 0, 0, 1);
        run_op("backpressure", 32'h1234, 16'hA5A5, 0, 10, 0, 0);

        // NOP: accepted and dropped with no ALU or writeback activity.
        issue_valid = 1'b1;
        issue_control = 32'h0;
        tick;
        issue_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("nop_ready", issue_ready, 1);
            check("nop_start", alu_start, 0);
            check("nop_wbv", wb_valid, 0);
            check("nop_busy", busy, 0);
            tick;
        end

        run_op("timeout", 32'h7, 16'hFFFF, TO + 5, 0, 0, 0);
        run_op("done_at_limit", 32'h9, 16'h0F0F, TO - 1, 2, 0, 0);
        run_op("exec_zero", 32'h3, 16'h0000, 0, 0, 0, 0);
        run_op("stale_done", 32'h5, 16'hFFFF, 2, 1, 1, 0);

        for (int n = 0; n < 20; n++) begin
            run_op("rand", $urandom | 32'h1, 16'($urandom), int'($urandom_range(0, TO + 1)),
                   int'($urandom_range(0, 3)), 1'($urandom), 0);
        end

        // Asynchronous reset while in WAIT: outputs drop immediately, instruction is lost.
        issue_valid = 1'b1;
        issue_control = 32'h11;
        issue_src1_data = rand512();
        issue_exec_value = 16'hFFFF;
        tick;
        issue_valid = 1'b0;
        tick;
        tick;
        check("rstwait_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rstwait");
        valu_done = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            check("rstwait_no_wbv", wb_valid, 0);
            check("rstwait_idle", issue_ready, 1);
        end
        valu_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/valu_issue_ctrl.md
# valu_issue_ctrl

Issue-side sequencer for the 16-lane vector ALU wrapper (valu). It accepts one vector instruction at a time from the issue stage and drives the ALU's operand, control and start inputs. It waits on valu_done, captures the lane results, and presents them to the writeback stage over a valid/ready handshake. It sits between issue and valu in each SIMD/SIMF pipe, and also supervises a watchdog timeout.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort (1..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  controller can accept
- issue_control  in  32  ALU opcode/control word; 0 = NOP
- issue_src1_data, issue_src2_data, issue_src3_data  in  512 each  operands, 16 x 32-bit lanes
- issue_vcc_value, issue_exec_value  in  16 each  per-lane VCC and EXEC
- issue_vgpr_addr  in  10  VGPR destination; issue_sgpr_addr  in  9  SGPR destination
- issue_wr_vgpr, issue_wr_sgpr, issue_wr_vcc  in  1 each  destination enables
- alu_source1_data, alu_source2_data, alu_source3_data  out  512 each  to ALU
- alu_source_vcc_value, alu_source_exec_value  out  16 each  to ALU
- alu_control  out  32  to ALU
- alu_start  out  1  to ALU
- alu_vgpr_dest_data  in  512  from ALU
- alu_sgpr_dest_data, alu_dest_vcc_value, alu_dest_exec_value  in  16 each  from ALU
- valu_done  in  1  from ALU
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_vgpr_data  out  512; wb_sgpr_data, wb_vcc_value, wb_exec_value  out  16 each  captured results
- wb_vgpr_addr  out  10; wb_sgpr_addr  out  9
- wb_vgpr_en, wb_sgpr_en, wb_vcc_en  out  1 each  write enables
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, START, WAIT, WB.
- In IDLE, issue_ready=1. Accept occurs on issue_valid & issue_ready. On accept, all issue_* fields are latched into an instruction register.
- Accept with issue_control==0 (NOP): the instruction is dropped. No ALU activity, no writeback, and the state stays IDLE.
- Accept with non-zero control: go to START.
- START lasts one cycle. alu_start=1 and the watchdog counter is cleared. valu_done is ignored in START because the previous op may leave it stale. Next state is WAIT.
- WAIT: the counter increments each cycle.
  - valu_done=1: capture the ALU outputs into the wb registers, then go to WB.
  - Counter reaches TIMEOUT_CYCLES-1 without done: pulse err_timeout, discard the instruction, go to IDLE.
  - Done takes priority over timeout when both occur in the same cycle.
- WB: wb_valid=1 and all wb_* outputs are held stable. On wb_ready, go to IDLE.
- alu_source*, vcc and exec outputs drive the latched instruction in START, WAIT and WB.
- alu_control drives the latched control word in START and WAIT, and is 0 in IDLE and WB. This keeps valu_done deasserted while the ALU is not owned.
- EXEC all-zero is legal. valu_done then rises in the first WAIT cycle. Results are written back with the captured exec_value; lane masking is the writeback stage's job.
- wb_*_en and addresses come from the latched instruction, not the ALU.

## Timing
- Reset values:
  - state IDLE
  - issue_ready=1
  - alu_start=0, alu_control=0, all alu_source* = 0
  - wb_valid=0, all wb_* data/addr/en = 0
  - busy=0, err_timeout=0
- Reset mid-operation aborts the in-flight instruction silently, with no err_timeout.
- Accept at edge T gives:
  - alu_start high in cycle T+1
  - first valu_done sample in cycle T+2
  - wb_valid earliest in cycle T+3
- wb_ready held high gives a WB→IDLE transition. The next accept is earliest one cycle after the WB handshake. Peak throughput is 1 instruction per 4 cycles.
- wb_valid is never deasserted without wb_ready; there is no timeout in WB.
- issue_ready is 0 in START, WAIT and WB, so there is no overlap.
- Watchdog: err_timeout pulses in the WAIT cycle where the count equals TIMEOUT_CYCLES-1, and IDLE is entered the next cycle.

## Test plan
- **Single op:** issue control=0x1, src1 lanes=0x5, exec=0xFFFF; model ALU done 2 cycles after start → alu_start one cycle at T+1, wb_valid at T+4, wb_vgpr_data equals model output, wb_vgpr_en=1.
- **Backpressure:** hold wb_ready=0 for 10 cycles in WB → wb_* stable, issue_ready=0, alu_control=0; release → IDLE next cycle, issue_ready=1.
- **NOP:** issue control=0 → no alu_start, no wb_valid, issue_ready stays 1.
- **Timeout:** TIMEOUT_CYCLES=8, valu_done never rises → err_timeout pulse 8 WAIT cycles after START, no wb_valid, back to IDLE. Also: done and timeout in the same cycle → WB taken, no err_timeout.
- **EXEC zero:** exec=0x0000 → done sampled in first WAIT cycle, wb_valid at T+3, wb_exec_value=0.
- **Reset in WAIT:** assert rst asynchronously → all outputs at reset values immediately, no wb_valid after release.
